// File: rtl/pool_binarize_if.sv
// Raster-stream bundle between the conv controller and the pooling/binarize stage.
interface pool_binarize_if #(
    parameter int unsigned N  = 6,
    parameter int unsigned DW = 16
);
    logic                   start;
    logic [N-1:0]           in_valid;
    logic [N-1:0][DW-1:0]   din;
    logic [N-1:0][DW-1:0]   pool;
    logic [N-1:0]           bin_out;
    logic                   out_valid;
    logic                   frame_done;
    logic                   err_mismatch;

    // Upstream side: drives the conv stream, observes pooled results.
    modport master (
        output start, in_valid, din,
        input  pool, bin_out, out_valid, frame_done, err_mismatch
    );

    // Pooling stage side.
    modport slave (
        input  start, in_valid, din,
        output pool, bin_out, out_valid, frame_done, err_mismatch
    );
endinterface

// File: rtl/pool_binarize.sv
// 2x2 stride-2 max pooling across N lockstep channels with BNN sign output.
// Horizontal pairs reduce into hreg; even rows park pair maxima in a
// half-width line buffer, odd rows combine with it and emit one result.
module pool_binarize #(
    parameter int unsigned N  = 6,
    parameter int unsigned W  = 24,
    parameter int unsigned H  = 24,
    parameter int unsigned DW = 16
) (
    input logic           clk,
    input logic           rst,
    pool_binarize_if.slave bus
);
    localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;
    localparam int unsigned RW = (H > 2) ? $clog2(H) : 1;
    localparam int unsigned LD = W / 2;
    localparam int unsigned LW = (LD > 1) ? $clog2(LD) : 1;

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic          accept, mismatch;
    logic          odd_col, odd_row, win_close, last_pos;
    logic [LW-1:0] lb_idx;

    logic signed [DW-1:0] hreg_q [N];
    logic signed [DW-1:0] hreg_d [N];
    logic signed [DW-1:0] hmax   [N];
    logic signed [DW-1:0] vmax   [N];
    logic signed [DW-1:0] lb_q   [N][LD];

    logic [N-1:0][DW-1:0] pool_q, pool_d;
    logic [N-1:0]         bin_q, bin_d;
    logic                 valid_q, valid_d;
    logic                 fd_q, fd_d;
    logic                 err_q, err_d;

    // Beat classification, position decode and per-channel max datapath.
    always_comb begin
        accept   = (bus.in_valid == {N{1'b1}});
        mismatch = (|bus.in_valid) && !accept;
        // start restarts the raster so a coincident beat lands at (0,0)
        col_cur  = bus.start ? '0 : col_q;
        row_cur  = bus.start ? '0 : row_q;
        odd_col  = col_cur[0];
        odd_row  = row_cur[0];
        lb_idx   = LW'(col_cur >> 1);
        last_pos = (row_cur == RW'(H - 1)) && (col_cur == CW'(W - 1));
        win_close = accept && odd_col && odd_row;
        for (int c = 0; c < int'(N); c++) begin
            hmax[c] = ($signed(bus.din[c]) > hreg_q[c]) ? $signed(bus.din[c]) : hreg_q[c];
            vmax[c] = (hmax[c] > lb_q[c][lb_idx]) ? hmax[c] : lb_q[c][lb_idx];
        end
    end

    // Next-state for counters, horizontal registers, outputs and error flag.
    always_comb begin
        col_d   = col_cur;
        row_d   = row_cur;
        pool_d  = pool_q;
        bin_d   = bin_q;
        valid_d = win_close;
        fd_d    = win_close && last_pos;
        err_d   = (bus.start ? 1'b0 : err_q) | mismatch;
        for (int c = 0; c < int'(N); c++) begin
            hreg_d[c] = bus.start ? '0 : hreg_q[c];
            if (accept && !odd_col) begin
                hreg_d[c] = $signed(bus.din[c]);
            end
            if (win_close) begin
                pool_d[c] = vmax[c];
                bin_d[c]  = ~vmax[c][DW-1];
            end
        end
        if (accept) begin
            if (col_cur == CW'(W - 1)) begin
                col_d = '0;
                row_d = (row_cur == RW'(H - 1)) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            pool_q  <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
            for (int c = 0; c < int'(N); c++) begin
                hreg_q[c] <= '0;
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pool_q  <= pool_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
            for (int c = 0; c < int'(N); c++) begin
                hreg_q[c] <= hreg_d[c];
            end
        end
    end

    // Line buffer: written on even rows, always rewritten before it is read.
    always_ff @(posedge clk) begin
        if (accept && odd_col && !odd_row) begin
            for (int c = 0; c < int'(N); c++) begin
                lb_q[c][lb_idx] <= hmax[c];
            end
        end
    end

    assign bus.pool         = pool_q;
    assign bus.bin_out      = bin_q;
    assign bus.out_valid    = valid_q;
    assign bus.frame_done   = fd_q;
    assign bus.err_mismatch = err_q;
endmodule

// File: tb/tb_pool_binarize.sv
// Directed bench for pool_binarize at W=4, H=4.
module tb_pool_binarize;
    localparam int N  = 6;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pool_binarize_if #(.N(N), .DW(DW)) bus ();

    pool_binarize #(.N(N), .W(W), .H(H), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int beats_sent   = 0;
    int err_hi_cnt   = 0;

    logic [N-1:0][DW-1:0] q_pool [$];
    logic [N-1:0]         q_bin  [$];
    logic                 q_fd   [$];
    int                   q_beat [$];

    // Window maxima for a 1..16 raster, and the beat that closes each window.
    int exp_val  [4] = '{6, 8, 14, 16};
    int exp_beat [4] = '{6, 8, 14, 16};

    // Output log, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            q_pool.push_back(bus.pool);
            q_bin.push_back(bus.bin_out);
            q_fd.push_back(bus.frame_done);
            q_beat.push_back(beats_sent);
        end
        if (bus.err_mismatch !== 1'b0) err_hi_cnt++;
    end

    function automatic logic [N-1:0][DW-1:0] raster(input int k);
        logic [N-1:0][DW-1:0] r;
        for (int c = 0; c < N; c++) r[c] = DW'(k + 100 * c);
        return r;
    endfunction

    // One cycle of stimulus: drive at negedge, accepted at posedge.
    task automatic drive(input logic [N-1:0] v, input logic [N-1:0][DW-1:0] d,
                         input logic st);
        bus.in_valid = v;
        bus.din      = d;
        bus.start    = st;
        @(posedge clk);
        #1;
        if (v == {N{1'b1}}) beats_sent++;
        bus.in_valid = '0;
        bus.start    = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive('0, '0, 1'b0);
    endtask

    task automatic send_frame(input int max_gap);
        for (int k = 1; k <= 16; k++) begin
            drive({N{1'b1}}, raster(k), 1'b0);
            idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic clear_log();
        q_pool.delete();
        q_bin.delete();
        q_fd.delete();
        q_beat.delete();
        beats_sent = 0;
        err_hi_cnt = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({bus.pool, bus.bin_out, bus.out_valid, bus.frame_done, bus.err_mismatch} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: pool=%h bin=%h ov=%b fd=%b err=%b required all 0",
                     bus.pool, bus.bin_out, bus.out_valid, bus.frame_done, bus.err_mismatch);
        end
        rst = 1'b0;
        idle(2);
        tests_run++;
        if ({bus.out_valid, bus.err_mismatch} !== 2'b00) begin
            tests_failed++;
            $display("FAIL post_reset_idle: ov=%b err=%b required 0 0", bus.out_valid,
                     bus.err_mismatch);
        end
    endtask

    task automatic test_basic();
        clear_log();
        send_frame(0);
        idle(2);
        tests_run++;
        if (q_pool.size() != 4) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d outputs required 4", q_pool.size());
        end
        for (int i = 0; i < 4 && i < q_pool.size(); i++) begin
            tests_run++;
            if (q_pool[i] !== raster(exp_val[i]) || q_bin[i] !== 6'h3F ||
                q_fd[i] !== (i == 3) || q_beat[i] != exp_beat[i]) begin
                tests_failed++;
                $display("FAIL basic_out%0d: pool=%h bin=%h fd=%b beat=%0d required %h 3f %b %0d",
                         i, q_pool[i], q_bin[i], q_fd[i], q_beat[i], raster(exp_val[i]),
                         (i == 3), exp_beat[i]);
            end
        end
        tests_run++;
        if (err_hi_cnt != 0) begin
            tests_failed++;
            $display("FAIL basic_err: err high %0d cycles required 0", err_hi_cnt);
        end
    endtask

    task automatic test_negative();
        logic [N-1:0][DW-1:0] d;
        logic [N-1:0][DW-1:0] e;
        clear_log();
        for (int k = 1; k <= 16; k++) begin
            d    = '0;
            d[0] = (k == 1) ? 16'h8000 : 16'hFFFB;
            drive({N{1'b1}}, d, 1'b0);
        end
        idle(2);
        e    = '0;
        e[0] = 16'hFFFB;
        tests_run++;
        if (q_pool.size() != 4) begin
            tests_failed++;
            $display("FAIL neg_count: got %0d outputs required 4", q_pool.size());
        end
        for (int i = 0; i < 4 && i < q_pool.size(); i++) begin
            tests_run++;
            if (q_pool[i] !== e || q_bin[i] !== 6'b111110 || q_fd[i] !== (i == 3)) begin
                tests_failed++;
                $display("FAIL neg_out%0d: pool=%h bin=%h fd=%b required %h 3e %b",
                         i, q_pool[i], q_bin[i], q_fd[i], e, (i == 3));
            end
        end
        tests_run++;
        if (err_hi_cnt != 0) begin
            tests_failed++;
            $display("FAIL neg_err: err high %0d cycles required 0", err_hi_cnt);
        end
    endtask

    task automatic test_mismatch();
        clear_log();
        for (int k = 1; k <= 5; k++) drive({N{1'b1}}, raster(k), 1'b0);
        drive(6'h01, raster(999), 1'b0);
        tests_run++;
        if (bus.err_mismatch !== 1'b1) begin
            tests_failed++;
            $display("FAIL mismatch_set: err=%b required 1", bus.err_mismatch);
        end
        for (int k = 6; k <= 16; k++) drive({N{1'b1}}, raster(k), 1'b0);
        idle(2);
        tests_run++;
        if (bus.err_mismatch !== 1'b1) begin
            tests_failed++;
            $display("FAIL mismatch_sticky: err=%b required 1", bus.err_mismatch);
        end
        tests_run++;
        if (q_pool.size() != 4) begin
            tests_failed++;
            $display("FAIL mismatch_count: got %0d outputs required 4", q_pool.size());
        end
        for (int i = 0; i < 4 && i < q_pool.size(); i++) begin
            tests_run++;
            if (q_pool[i] !== raster(exp_val[i]) || q_fd[i] !== (i == 3) ||
                q_beat[i] != exp_beat[i]) begin
                tests_failed++;
                $display("FAIL mismatch_out%0d: pool=%h fd=%b beat=%0d required %h %b %0d",
                         i, q_pool[i], q_fd[i], q_beat[i], raster(exp_val[i]), (i == 3),
                         exp_beat[i]);
            end
        end
        drive('0, '0, 1'b1);
        tests_run++;
        if (bus.err_mismatch !== 1'b0) begin
            tests_failed++;
            $display("FAIL mismatch_clear: err=%b required 0 after start", bus.err_mismatch);
        end
    endtask

    task automatic test_start_mid();
        clear_log();
        for (int k = 1; k <= 7; k++) drive({N{1'b1}}, raster(k), 1'b0);
        clear_log();
        drive({N{1'b1}}, raster(1), 1'b1);
        for (int k = 2; k <= 16; k++) drive({N{1'b1}}, raster(k), 1'b0);
        idle(2);
        tests_run++;
        if (q_pool.size() != 4) begin
            tests_failed++;
            $display("FAIL start_count: got %0d outputs required 4", q_pool.size());
        end
        for (int i = 0; i < 4 && i < q_pool.size(); i++) begin
            tests_run++;
            if (q_pool[i] !== raster(exp_val[i]) || q_fd[i] !== (i == 3) ||
                q_beat[i] != exp_beat[i]) begin
                tests_failed++;
                $display("FAIL start_out%0d: pool=%h fd=%b beat=%0d required %h %b %0d",
                         i, q_pool[i], q_fd[i], q_beat[i], raster(exp_val[i]), (i == 3),
                         exp_beat[i]);
            end
        end
        tests_run++;
        if (err_hi_cnt != 0) begin
            tests_failed++;
            $display("FAIL start_err: err high %0d cycles required 0", err_hi_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int fd_cnt;
        clear_log();
        send_frame(3);
        send_frame(3);
        idle(2);
        tests_run++;
        if (q_pool.size() != 8) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d outputs required 8", q_pool.size());
        end
        fd_cnt = 0;
        for (int i = 0; i < 8 && i < q_pool.size(); i++) begin
            if (q_fd[i] === 1'b1) fd_cnt++;
            tests_run++;
            if (q_pool[i] !== raster(exp_val[i % 4]) || q_fd[i] !== (i % 4 == 3) ||
                q_beat[i] != exp_beat[i % 4] + 16 * (i / 4)) begin
                tests_failed++;
                $display("FAIL b2b_out%0d: pool=%h fd=%b beat=%0d required %h %b %0d",
                         i, q_pool[i], q_fd[i], q_beat[i], raster(exp_val[i % 4]),
                         (i % 4 == 3), exp_beat[i % 4] + 16 * (i / 4));
            end
        end
        tests_run++;
        if (fd_cnt != 2) begin
            tests_failed++;
            $display("FAIL b2b_frame_done: got %0d pulses required 2", fd_cnt);
        end
        tests_run++;
        if (err_hi_cnt != 0) begin
            tests_failed++;
            $display("FAIL b2b_err: err high %0d cycles required 0", err_hi_cnt);
        end
    endtask

    task automatic test_rst_mid();
        clear_log();
        for (int k = 1; k <= 10; k++) drive({N{1'b1}}, raster(k), 1'b0);
        tests_run++;
        if (bus.pool !== raster(8) || bus.bin_out !== 6'h3F) begin
            tests_failed++;
            $display("FAIL rst_pre_hold: pool=%h bin=%h required %h 3f", bus.pool,
                     bus.bin_out, raster(8));
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.pool, bus.bin_out, bus.out_valid, bus.frame_done, bus.err_mismatch} !== '0) begin
            tests_failed++;
            $display("FAIL rst_async_clear: pool=%h bin=%h ov=%b fd=%b err=%b required all 0",
                     bus.pool, bus.bin_out, bus.out_valid, bus.frame_done, bus.err_mismatch);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        send_frame(0);
        idle(2);
        tests_run++;
        if (q_pool.size() != 4) begin
            tests_failed++;
            $display("FAIL rst_count: got %0d outputs required 4", q_pool.size());
        end
        for (int i = 0; i < 4 && i < q_pool.size(); i++) begin
            tests_run++;
            if (q_pool[i] !== raster(exp_val[i]) || q_fd[i] !== (i == 3) ||
                q_beat[i] != exp_beat[i]) begin
                tests_failed++;
                $display("FAIL rst_out%0d: pool=%h fd=%b beat=%0d required %h %b %0d",
                         i, q_pool[i], q_fd[i], q_beat[i], raster(exp_val[i]), (i == 3),
                         exp_beat[i]);
            end
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = '0;
        bus.din      = '0;
        test_reset();
        test_basic();
        test_negative();
        test_mismatch();
        test_start_mid();
        test_back_to_back();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
